load_align_unit: RTL and testbench

Parametrised, handshaked load-data unit between the core's load path and the AXI4 read master. Accepts a load request (address + fun3), issues one or two bus-aligned read beats, then merges, byte-aligns and sign/zero-extends the returned data. It covers lb/lh/lw/ld/lbu/lhu/lwu and reports bus and decode errors. It replaces the purely combinational load sign-extension path.

---
 rtl/load_align_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_align_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// load_align_unit: handshaked load-data unit between the core load path and
// the AXI4 read master. Issues one (or, for spanning loads, two) bus-aligned
// read beats, then merges, byte-aligns and sign/zero-extends the result.
// Optional feature macro: MISALIGN_SPLIT_EN. When defined, loads that span a
// beat boundary are split into two beats. When undefined, such loads fault
// without touching the bus.
module load_align_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_fun3,
  output logic            mem_rd_valid,
  input  logic            mem_rd_ready,
  output logic [XLEN-1:0] mem_rd_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_WAIT0,
`ifdef MISALIGN_SPLIT_EN
    S_ISSUE1,
    S_WAIT1,
`endif
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      fun3_q, fun3_d;
  logic [OW-1:0]   offset_q, offset_d;
  logic [XLEN-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
`ifdef MISALIGN_SPLIT_EN
  logic [XLEN-1:0] beat0_q, beat0_d;
`endif

  // fun3 values this XLEN can execute; 111 never, ld/lwu only on RV64.
  function automatic logic fun3_legal(input logic [2:0] f);
    if (f == 3'b111) return 1'b0;
    if ((XLEN == 32) && ((f == 3'b011) || (f == 3'b110))) return 1'b0;
    return 1'b1;
  endfunction

  // True when the access runs past the end of its first beat.
  function automatic logic is_span(input logic [OW-1:0] off, input logic [1:0] code);
    logic [OW+1:0] sum;
    sum = (OW+2)'(off) + ((OW+2)'(1) << code);
    return sum > (OW+2)'(NB);
  endfunction

  // Shift the two-beat window down to the addressed byte, then keep the
  // access width and extend per fun3[2]. A full-width load is passed through.
  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] hi,
                                            input logic [XLEN-1:0] lo,
                                            input logic [OW-1:0]   off,
                                            input logic [2:0]      f);
    logic [2*XLEN-1:0] window;
    logic [XLEN-1:0]   low;
    logic [XLEN-1:0]   mask;
    logic              sign;
    int                nbits;
    window = {hi, lo} >> {off, 3'b000};
    low    = window[XLEN-1:0];
    nbits  = 8 << f[1:0];
    if (nbits >= XLEN) return low;
    mask = ~({XLEN{1'b1}} << nbits);
    sign = ~f[2] & low[nbits-1];
    return (low & mask) | ({XLEN{sign}} & ~mask);
  endfunction

  // Handshake strobes decode straight from the state register.
  assign req_ready    = (state_q == S_IDLE) && !rst;
`ifdef MISALIGN_SPLIT_EN
  assign mem_rd_valid = (state_q == S_ISSUE0) || (state_q == S_ISSUE1);
`else
  assign mem_rd_valid = (state_q == S_ISSUE0);
`endif
  assign rsp_valid    = (state_q == S_DONE);
  assign mem_rd_addr  = mem_rd_addr_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;

  // Next-state and next-datapath computation for the load sequencer.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    fun3_d        = fun3_q;
    offset_d      = offset_q;
    mem_rd_addr_d = mem_rd_addr_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
`ifdef MISALIGN_SPLIT_EN
    beat0_d       = beat0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fun3_d     = req_fun3;
          offset_d   = req_addr[OW-1:0];
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (!fun3_legal(req_fun3)) begin
            state_d   = S_DONE;
            rsp_err_d = 1'b1;
          end
`ifndef MISALIGN_SPLIT_EN
          else if (is_span(req_addr[OW-1:0], req_fun3[1:0])) begin
            state_d   = S_DONE;
            rsp_err_d = 1'b1;
          end
`endif
          else begin
            state_d       = S_ISSUE0;
            mem_rd_addr_d = {req_addr[XLEN-1:OW], OW'(0)};
          end
        end
      end
      S_ISSUE0: if (mem_rd_ready) state_d = S_WAIT0;
      S_WAIT0: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            state_d    = S_DONE;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
`ifdef MISALIGN_SPLIT_EN
          else if (is_span(offset_q, fun3_q[1:0])) begin
            state_d       = S_ISSUE1;
            beat0_d       = mem_rsp_data;
            mem_rd_addr_d = mem_rd_addr_q + XLEN'(NB);
          end
`endif
          else begin
            state_d    = S_DONE;
            rsp_data_d = align('0, mem_rsp_data, offset_q, fun3_q);
          end
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_ISSUE1: if (mem_rd_ready) state_d = S_WAIT1;
      S_WAIT1: begin
        if (mem_rsp_valid) begin
          state_d = S_DONE;
          if (mem_rsp_err) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            rsp_data_d = align(mem_rsp_data, beat0_q, offset_q, fun3_q);
          end
        end
      end
`endif
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= S_IDLE;
      fun3_q        <= '0;
      offset_q      <= '0;
      mem_rd_addr_q <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      beat0_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fun3_q        <= fun3_d;
      offset_q      <= offset_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
`ifdef MISALIGN_SPLIT_EN
      beat0_q       <= beat0_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed testbench for load_align_unit (XLEN = 64). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_fun3;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [63:0] mem_rd_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  load_align_unit #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_fun3     (req_fun3),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_err  (mem_rsp_err),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One complete load with a zero-wait bus model; called just after a falling edge.
  task automatic run_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] b0, input logic [63:0] b1, input logic e0,
                          input logic [63:0] exp_data, input logic exp_err,
                          input int exp_beats, input logic [63:0] exp_addr0);
    int lat;
    int beats;
    req_valid = 1'b1;
    req_addr  = addr;
    req_fun3  = f3;
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat   = 1;
    beats = 0;
    while (!rsp_valid && lat < 40) begin
      if (mem_rd_valid) begin
        check({tag, ".beat_addr"}, mem_rd_addr, exp_addr0 + 64'(beats * 8));
        mem_rd_ready = 1'b1;
        @(negedge clk);
        lat++;
        mem_rd_ready  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = (beats == 0) ? b0 : b1;
        mem_rsp_err   = (beats == 0) ? e0 : 1'b0;
        @(negedge clk);
        lat++;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_data  = '0;
        beats++;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, ".rsp_data"},  rsp_data, exp_data);
    check({tag, ".rsp_err"},   64'(rsp_err), 64'(exp_err));
    check({tag, ".beats"},     64'(beats), 64'(exp_beats));
    check({tag, ".latency"},   64'(lat), 64'(1 + 2 * exp_beats));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rsp_released"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_fun3 = '0;
    mem_rd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst.req_ready",    64'(req_ready),    64'd0);
    check("rst.rsp_valid",    64'(rsp_valid),    64'd0);
    check("rst.mem_rd_valid", 64'(mem_rd_valid), 64'd0);
    check("rst.mem_rd_addr",  mem_rd_addr,       64'd0);
    check("rst.rsp_data",     rsp_data,          64'd0);
    check("rst.rsp_err",      64'(rsp_err),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic aligned and in-beat misaligned loads
    run_load("lb_1003", 64'h1003, 3'b000, 64'h0000_0000_8000_0000, '0, 1'b0,
             64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 64'h1000);
    run_load("lhu_1006", 64'h1006, 3'b101, 64'h1234_0000_0000_0000, '0, 1'b0,
             64'h0000_0000_0000_1234, 1'b0, 1, 64'h1000);
    run_load("lh_2001", 64'h2001, 3'b001, 64'h0000_0000_00F0_0100, '0, 1'b0,
             64'hFFFF_FFFF_FFFF_F001, 1'b0, 1, 64'h2000);
    run_load("lwu_3004", 64'h3004, 3'b110, 64'h89AB_CDEF_0000_0000, '0, 1'b0,
             64'h0000_0000_89AB_CDEF, 1'b0, 1, 64'h3000);
    run_load("lw_3004", 64'h3004, 3'b010, 64'h89AB_CDEF_0000_0000, '0, 1'b0,
             64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1, 64'h3000);
    run_load("lbu_5007", 64'h5007, 3'b100, 64'hFF00_0000_0000_0000, '0, 1'b0,
             64'h0000_0000_0000_00FF, 1'b0, 1, 64'h5000);

    // Spanning loads
`ifdef MISALIGN_SPLIT_EN
    run_load("lw_100e_split", 64'h100E, 3'b010, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_DEAD, 1'b0,
             64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 2, 64'h1008);
    run_load("ld_split_err", 64'h4004, 3'b011, 64'h1111_2222_3333_4444, '0, 1'b1,
             64'h0, 1'b1, 1, 64'h4000);
    run_load("lh_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 64'h8800_0000_0000_0000, 64'h0000_0000_0000_0077, 1'b0,
             64'h0000_0000_0000_7788, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFF8);
`else
    run_load("lw_100e_nosplit", 64'h100E, 3'b010, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_DEAD, 1'b0,
             64'h0, 1'b1, 0, 64'h1008);
    run_load("ld_span_nosplit", 64'h4004, 3'b011, 64'h1111_2222_3333_4444, '0, 1'b0,
             64'h0, 1'b1, 0, 64'h4000);
`endif

    // Bus error on an aligned beat, and an illegal fun3
    run_load("ld_buserr", 64'h4000, 3'b011, 64'h1111_2222_3333_4444, '0, 1'b1,
             64'h0, 1'b1, 1, 64'h4000);
    run_load("fun3_111", 64'h4000, 3'b111, '0, '0, 1'b0,
             64'h0, 1'b1, 0, 64'h4000);

    // Stalled bus and stalled consumer, with stray responses ignored
    req_valid = 1'b1; req_addr = 64'h6000; req_fun3 = 3'b011;
    @(negedge clk);
    req_valid = 1'b0;
    check("stall.mem_rd_valid", 64'(mem_rd_valid), 64'd1);
    check("stall.mem_rd_addr",  mem_rd_addr,       64'h6000);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hDEAD_DEAD_DEAD_DEAD;
      end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      check("stall.issue_hold_valid", 64'(mem_rd_valid), 64'd1);
      check("stall.issue_hold_addr",  mem_rd_addr,       64'h6000);
    end
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    check("stall.rsp_valid", 64'(rsp_valid), 64'd1);
    check("stall.rsp_data",  rsp_data,       64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hAAAA_AAAA_AAAA_AAAA;
      end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      check("stall.rsp_hold_valid", 64'(rsp_valid), 64'd1);
      check("stall.rsp_hold_data",  rsp_data,       64'h0123_4567_89AB_CDEF);
      check("stall.rsp_hold_err",   64'(rsp_err),   64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall.rsp_released", 64'(rsp_valid), 64'd0);

    // Back-to-back: the next request goes in right after the handshake
    run_load("b2b_ld", 64'h6008, 3'b011, 64'hFEDC_BA98_7654_3210, '0, 1'b0,
             64'hFEDC_BA98_7654_3210, 1'b0, 1, 64'h6008);

    // Reset while waiting for a beat, then a stale response
    req_valid = 1'b1; req_addr = 64'h7000; req_fun3 = 3'b011;
    @(negedge clk);
    req_valid = 1'b0;
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst.req_ready",    64'(req_ready),    64'd0);
    check("midrst.rsp_valid",    64'(rsp_valid),    64'd0);
    check("midrst.mem_rd_valid", 64'(mem_rd_valid), 64'd0);
    check("midrst.mem_rd_addr",  mem_rd_addr,       64'd0);
    check("midrst.rsp_data",     rsp_data,          64'd0);
    check("midrst.rsp_err",      64'(rsp_err),      64'd0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h5555_5555_5555_5555;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    check("stale.req_ready",    64'(req_ready),    64'd1);
    check("stale.rsp_valid",    64'(rsp_valid),    64'd0);
    check("stale.mem_rd_valid", 64'(mem_rd_valid), 64'd0);
    check("stale.rsp_data",     rsp_data,          64'd0);
    run_load("post_rst_lh", 64'h7002, 3'b001, 64'h0000_0000_7FFF_0000, '0, 1'b0,
             64'h0000_0000_0000_7FFF, 1'b0, 1, 64'h7000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
